// File: rtl/mpc_arith_pkg.sv
// Shared arithmetic definitions for the MPC cost-evaluation datapath.
//   - NUM_STAGE_MIN / NUM_STAGE_MAX : legal pipeline depth range of mpc_mac_pipe
//   - side_t      : per-stage sideband record (valid, mode, acc_clr)
//   - clip_t      : result of a signed clip (overflow flag + clipped value)
//   - clip_signed : clip a signed value to the signed range of a target width
package mpc_arith_pkg;

  localparam int unsigned NUM_STAGE_MIN = 3;
  localparam int unsigned NUM_STAGE_MAX = 8;

  // Working width of the clip helper; every clipped quantity must fit in it.
  localparam int unsigned CLIP_W = 64;

  typedef struct packed {
    logic valid;
    logic mode;     // 0 = multiply, 1 = accumulate
    logic acc_clr;  // start a new sum (accumulate mode only)
  } side_t;

  typedef struct packed {
    logic                     ovf;
    logic signed [CLIP_W-1:0] value;
  } clip_t;

  // Clip val to [-2^(width-1), 2^(width-1)-1]; ovf reports that clipping occurred.
  function automatic clip_t clip_signed(input logic signed [CLIP_W-1:0] val,
                                        input int unsigned               width);
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    clip_t                    res;
    hi        = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo        = ~hi;
    res.ovf   = 1'b0;
    res.value = val;
    if (val > hi) begin
      res.value = hi;
      res.ovf   = 1'b1;
    end else if (val < lo) begin
      res.value = lo;
      res.ovf   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mpc_mac_pipe_if.sv
// Sample/result bus of mpc_mac_pipe.
//   master : producer side - drives in_valid/a/b/mode/acc_clr, observes results
//   slave  : mpc_mac_pipe  - consumes the sample, drives out_valid/p/ovf
// Signal meanings: in_valid qualifies a/b/mode/acc_clr; out_valid qualifies p/ovf
// (consumer must also qualify with ce, since out_valid holds while ce=0).
interface mpc_mac_pipe_if #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 6,
  parameter int unsigned OUT_W = 22
);
  logic                    in_valid;
  logic signed [A_W-1:0]   a;
  logic        [B_W-1:0]   b;
  logic                    mode;
  logic                    acc_clr;
  logic                    out_valid;
  logic signed [OUT_W-1:0] p;
  logic                    ovf;

  modport master (output in_valid, a, b, mode, acc_clr,
                  input  out_valid, p, ovf);
  modport slave  (input  in_valid, a, b, mode, acc_clr,
                  output out_valid, p, ovf);
endinterface

// File: rtl/mpc_sat_clip.sv
// Combinational signed clip of an IN_W-bit value to OUT_W bits.
//   val_i : signed input value
//   val_o : value clipped to the OUT_W signed range
//   ovf_o : 1 when val_i was outside the OUT_W signed range
module mpc_sat_clip
  import mpc_arith_pkg::*;
#(
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] val_o,
  output logic                    ovf_o
);

  clip_t                    res;
  // After clipping the bits above OUT_W are only sign copies.
  logic [CLIP_W-OUT_W-1:0]  unused_hi;

  assign res       = clip_signed(CLIP_W'(val_i), OUT_W);
  assign val_o     = res.value[OUT_W-1:0];
  assign unused_hi = res.value[CLIP_W-1:OUT_W];
  assign ovf_o     = res.ovf;

endmodule

// File: rtl/mpc_mac_pipe.sv
// Pipelined signed multiplier / multiply-accumulator for MPC cost evaluation.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   ce      : clock enable, low freezes every register including valids
//   bus     : slave side of mpc_mac_pipe_if (sample in, result out)
// Latency NUM_STAGE cycles (S1 input regs, S2 product, S3..S(N-1) delay,
// SN result/accumulator), one sample per enabled cycle.
module mpc_mac_pipe
  import mpc_arith_pkg::*;
#(
  parameter int unsigned A_W       = 16,
  parameter int unsigned B_W       = 6,
  parameter bit          B_SIGNED  = 1'b0,
  parameter int unsigned OUT_W     = 22,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned NUM_STAGE = 4,
  parameter bit          SAT_EN    = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  input logic           ce,
  mpc_mac_pipe_if.slave bus
);

  localparam int unsigned PW    = A_W + B_W;
  localparam int unsigned SUM_W = ACC_W + 1;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("mpc_mac_pipe: NUM_STAGE outside legal range");
  end
  if (ACC_W < PW) begin : g_bad_acc
    $error("mpc_mac_pipe: ACC_W must be >= A_W+B_W");
  end

  logic signed [A_W-1:0] a_q;
  logic        [B_W-1:0] b_q;
  logic signed [PW-1:0]  b_ext;
  logic signed [PW-1:0]  prod_d;
  side_t                 side_in;
  side_t                 side_q [1:NUM_STAGE-1];
  logic signed [PW-1:0]  prod_q [2:NUM_STAGE-1];

  assign side_in = '{valid: bus.in_valid, mode: bus.mode, acc_clr: bus.acc_clr};

  // Both operands widened to PW first; the true product always fits in PW.
  assign b_ext  = B_SIGNED ? PW'($signed(b_q)) : PW'(b_q);
  assign prod_d = PW'(a_q) * b_ext;

  // S1 input registers and S2 product register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: data registers are reset as well as valids, so in-flight samples are discarded and outputs read zero.
      a_q       <= '0;
      b_q       <= '0;
      side_q[1] <= '0;
      prod_q[2] <= '0;
      side_q[2] <= '0;
    end else if (ce) begin
      // NOTE: non-blocking assignments so each stage captures the previous stage's pre-edge value.
      a_q       <= bus.a;
      b_q       <= bus.b;
      side_q[1] <= side_in;
      prod_q[2] <= prod_d;
      side_q[2] <= side_q[1];
    end
  end

  // S3..S(N-1): plain delay stages carrying the product and its sideband.
  for (genvar s = 3; s < NUM_STAGE; s++) begin : g_dly
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prod_q[s] <= '0;
        side_q[s] <= '0;
      end else if (ce) begin
        prod_q[s] <= prod_q[s-1];
        side_q[s] <= side_q[s-1];
      end
    end
  end

  // SN: result stage.
  side_t                   res_side;
  logic signed [PW-1:0]    res_prod;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod_x, acc_sum_clip, r;
  logic signed [SUM_W-1:0] acc_sum;
  logic                    acc_sum_ovf, acc_ovf, out_ovf, ovf_d;
  logic signed [OUT_W-1:0] p_clip, p_d;
  logic                    out_valid_q, ovf_q;
  logic signed [OUT_W-1:0] p_q;

  assign res_side = side_q[NUM_STAGE-1];
  assign res_prod = prod_q[NUM_STAGE-1];
  assign prod_x   = ACC_W'(res_prod);
  // One guard bit so the raw sum is exact before clipping to ACC_W.
  assign acc_sum  = SUM_W'(acc_q) + SUM_W'(res_prod);

  mpc_sat_clip #(.IN_W(SUM_W), .OUT_W(ACC_W)) u_acc_clip (
    .val_i (acc_sum),
    .val_o (acc_sum_clip),
    .ovf_o (acc_sum_ovf)
  );

  mpc_sat_clip #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_out_clip (
    .val_i (r),
    .val_o (p_clip),
    .ovf_o (out_ovf)
  );

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    acc_d   = acc_q;
    r       = prod_x;
    acc_ovf = 1'b0;
    if (res_side.mode) begin
      if (res_side.acc_clr) begin
        acc_d = prod_x;
      end else begin
        acc_d   = acc_sum_clip;
        acc_ovf = acc_sum_ovf;
      end
      r = acc_d;
    end
    p_d   = SAT_EN ? p_clip : r[OUT_W-1:0];
    ovf_d = acc_ovf | out_ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (ce) begin
      out_valid_q <= res_side.valid;
      // Non-valid stage slots leave result and accumulator untouched.
      if (res_side.valid) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
        acc_q <= acc_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.ovf       = ovf_q;

endmodule
